// File: rtl/key_event_fifo.sv
// Debounces raw key-down samples into one event per press and queues the
// event codes in a small first-word-fall-through FIFO for the consumer.
module key_event_fifo #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEPTH           = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       KeyRead,
  input  logic [3:0] BCDKey,
  input  logic       KeyAck,
  input  logic       OvfClear,
  output logic       EnableKeyb,
  output logic       KeyValid,
  output logic [3:0] KeyCode,
  output logic [2:0] Count,
  output logic       Overflow
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]       DEPTH_L  = 3'(DEPTH);
  localparam logic [3:0]       DEB_L    = 4'(DEBOUNCE_CYCLES);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [3:0]       code_q;
  logic [3:0]       cnt_inc;
  logic             same_code;
  logic             push;

  logic [3:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [2:0]       count_q, count_d;
  logic [3:0]       keycode_q, keycode_d;
  logic             ovf_q, ovf_d;
  logic             en_q, en_d;
  logic             pop_eff, push_eff, full, ovf_set;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign cnt_inc   = cnt_q + 4'd1;
  assign same_code = (BCDKey == code_q);
  // The accepting edge pushes directly, so the event is visible right after it.
  assign push      = (state_q == PRESS_CHK) && KeyRead && same_code && (cnt_inc == DEB_L);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      code_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (KeyRead) begin
            state_q <= PRESS_CHK;
            code_q  <= BCDKey;
            cnt_q   <= 4'd1;
          end
        end
        PRESS_CHK: begin
          if (!KeyRead) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end else if (!same_code) begin
            code_q  <= BCDKey;
            cnt_q   <= 4'd1;
          end else if (cnt_inc == DEB_L) begin
            state_q <= HELD;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q   <= cnt_inc;
          end
        end
        HELD: begin
          if (!KeyRead) begin
            state_q <= REL_CHK;
            cnt_q   <= 4'd1;
          end
        end
        REL_CHK: begin
          if (KeyRead) begin
            state_q <= HELD;
            cnt_q   <= 4'd0;
          end else if (cnt_inc == DEB_L) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q   <= cnt_inc;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  assign full     = (count_q == DEPTH_L);
  assign pop_eff  = KeyAck && (count_q != 3'd0);
  assign push_eff = push && (!full || pop_eff);
  assign ovf_set  = push && full && !pop_eff;

  always_comb begin
    wr_d      = push_eff ? ptr_inc(wr_q) : wr_q;
    rd_d      = pop_eff  ? ptr_inc(rd_q) : rd_q;
    count_d   = count_q;
    if (push_eff && !pop_eff) begin
      count_d = count_q + 3'd1;
    end else if (!push_eff && pop_eff) begin
      count_d = count_q - 3'd1;
    end
    // New head is the incoming code when it lands where the read pointer will be.
    keycode_d = keycode_q;
    if (count_d != 3'd0) begin
      keycode_d = (push_eff && (rd_d == wr_q)) ? code_q : mem_q[rd_d];
    end
    ovf_d     = ovf_set ? 1'b1 : (OvfClear ? 1'b0 : ovf_q);
    en_d      = (count_d < DEPTH_L);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= 3'd0;
      keycode_q <= 4'h0;
      ovf_q     <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      keycode_q <= keycode_d;
      ovf_q     <= ovf_d;
      en_q      <= en_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_eff) begin
      mem_q[wr_q] <= code_q;
    end
  end

  assign EnableKeyb = en_q;
  assign KeyValid   = (count_q != 3'd0);
  assign KeyCode    = keycode_q;
  assign Count      = count_q;
  assign Overflow   = ovf_q;

endmodule

// File: tb/tb_key_event_fifo.sv
// Directed bench for key_event_fifo: a queue-based model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_key_event_fifo;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       KeyRead, KeyAck, OvfClear;
  logic [3:0] BCDKey;
  logic       EnableKeyb, KeyValid, Overflow;
  logic [3:0] KeyCode;
  logic [2:0] Count;

  int checks = 0;
  int errors = 0;

  key_event_fifo #(.DEBOUNCE_CYCLES(N), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .KeyRead(KeyRead), .BCDKey(BCDKey),
    .KeyAck(KeyAck), .OvfClear(OvfClear), .EnableKeyb(EnableKeyb),
    .KeyValid(KeyValid), .KeyCode(KeyCode), .Count(Count), .Overflow(Overflow)
  );

  always #5 CLK = ~CLK;

  // Model: a press is accepted after N consecutive high samples with one code
  // and released after N consecutive lows; accepted presses go into a queue.
  logic [3:0] mq[$];
  bit         pressed   = 0;
  int         hi_run    = 0;
  int         lo_run    = 0;
  logic [3:0] hi_code   = 4'h0;
  logic [3:0] last_code = 4'h0;
  bit         m_ovf     = 0;
  bit         m_en      = 0;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mq.delete();
      pressed = 0; hi_run = 0; lo_run = 0; hi_code = 4'h0;
      last_code = 4'h0; m_ovf = 0; m_en = 0;
    end else begin
      bit accept, popq;
      int had;
      accept = 0;
      if (!pressed) begin
        if (KeyRead) begin
          if (hi_run > 0 && BCDKey == hi_code) hi_run++;
          else begin hi_run = 1; hi_code = BCDKey; end
          if (hi_run == N) begin accept = 1; pressed = 1; lo_run = 0; end
        end else begin
          hi_run = 0;
        end
      end else begin
        if (KeyRead) lo_run = 0;
        else begin
          lo_run++;
          if (lo_run == N) begin pressed = 0; hi_run = 0; end
        end
      end
      had  = mq.size();
      popq = KeyAck && had > 0;
      if (popq) void'(mq.pop_front());
      if (OvfClear) m_ovf = 0;
      if (accept) begin
        if (had < DEPTH || popq) mq.push_back(hi_code);
        else m_ovf = 1;
      end
      if (mq.size() > 0) last_code = mq[0];
      m_en = (mq.size() < DEPTH);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("m_valid", 32'(KeyValid), 32'(mq.size() != 0));
    chk("m_count", 32'(Count), 32'(mq.size()));
    chk("m_code", 32'(KeyCode), 32'(last_code));
    chk("m_ovf", 32'(Overflow), 32'(m_ovf));
    chk("m_en", 32'(EnableKeyb), 32'(m_en));
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cyc(input logic kr, input logic [3:0] code, input logic ack,
                     input logic oc, input int n);
    KeyRead = kr; BCDKey = code; KeyAck = ack; OvfClear = oc;
    repeat (n) tick();
  endtask

  task automatic press(input logic [3:0] code, input logic oc);
    cyc(1'b1, code, 1'b0, oc, N);
    cyc(1'b0, code, 1'b0, 1'b0, N);
  endtask

  task automatic pop_expect(input string name, input logic [3:0] exp);
    chk(name, 32'(KeyCode), 32'(exp));
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    RESET_N = 1'b0; KeyRead = 1'b0; BCDKey = 4'h0; KeyAck = 1'b0; OvfClear = 1'b0;
    repeat (2) tick();
    chk("rst_valid", 32'(KeyValid), 0);
    chk("rst_en", 32'(EnableKeyb), 0);
    chk("rst_code", 32'(KeyCode), 0);
    RESET_N = 1'b1;
    tick();
    chk("en_after_rst", 32'(EnableKeyb), 1);

    // Clean press, long hold
    cyc(1'b1, 4'h7, 1'b0, 1'b0, 3);
    chk("clean_3edges", 32'(Count), 0);
    cyc(1'b1, 4'h7, 1'b0, 1'b0, 1);
    chk("clean_valid", 32'(KeyValid), 1);
    chk("clean_code", 32'(KeyCode), 32'h7);
    chk("clean_count", 32'(Count), 1);
    cyc(1'b1, 4'h7, 1'b0, 1'b0, 50);
    chk("hold_count", 32'(Count), 1);
    cyc(1'b0, 4'h7, 1'b0, 1'b0, N);
    pop_expect("clean_pop", 4'h7);
    chk("hold_code_empty", 32'(KeyCode), 32'h7);

    // Bounce, then release glitch while held
    cyc(1'b1, 4'h5, 1'b0, 1'b0, 3);
    cyc(1'b0, 4'h5, 1'b0, 1'b0, 1);
    cyc(1'b1, 4'h5, 1'b0, 1'b0, 4);
    chk("bounce_count", 32'(Count), 1);
    chk("bounce_code", 32'(KeyCode), 32'h5);
    cyc(1'b0, 4'h5, 1'b0, 1'b0, 2);
    cyc(1'b1, 4'h5, 1'b0, 1'b0, 6);
    chk("glitch_count", 32'(Count), 1);
    cyc(1'b0, 4'h5, 1'b0, 1'b0, N);
    pop_expect("bounce_pop", 4'h5);

    // Code change while qualifying; HELD ignores code changes
    cyc(1'b1, 4'h3, 1'b0, 1'b0, 2);
    cyc(1'b1, 4'h9, 1'b0, 1'b0, 4);
    chk("chg_count", 32'(Count), 1);
    chk("chg_code", 32'(KeyCode), 32'h9);
    cyc(1'b1, 4'h2, 1'b0, 1'b0, 6);
    chk("held_ignore", 32'(Count), 1);
    cyc(1'b0, 4'h2, 1'b0, 1'b0, N);
    pop_expect("chg_pop", 4'h9);

    // Fill and overflow; the fifth press also holds OvfClear so the set must win
    for (int c = 1; c <= 4; c++) press(4'(c), 1'b0);
    chk("full_count", 32'(Count), 4);
    chk("full_en", 32'(EnableKeyb), 0);
    press(4'h5, 1'b1);
    chk("ovf_count", 32'(Count), 4);
    chk("ovf_set", 32'(Overflow), 1);
    chk("ovf_head", 32'(KeyCode), 32'h1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1);
    chk("ovf_clear", 32'(Overflow), 0);

    // Full with simultaneous push and pop
    cyc(1'b1, 4'h6, 1'b0, 1'b0, 3);
    cyc(1'b1, 4'h6, 1'b1, 1'b0, 1);
    chk("pp_count", 32'(Count), 4);
    chk("pp_head", 32'(KeyCode), 32'h2);
    chk("pp_ovf", 32'(Overflow), 0);
    cyc(1'b0, 4'h6, 1'b0, 1'b0, N);
    pop_expect("pop_2", 4'h2);
    pop_expect("pop_3", 4'h3);
    pop_expect("pop_4", 4'h4);
    pop_expect("pop_6", 4'h6);
    chk("drain_count", 32'(Count), 0);
    chk("drain_en", 32'(EnableKeyb), 1);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 2);
    chk("ack_empty", 32'(Count), 0);

    // Push into empty with KeyAck on the same edge
    cyc(1'b1, 4'hA, 1'b0, 1'b0, 3);
    cyc(1'b1, 4'hA, 1'b1, 1'b0, 1);
    chk("empty_pp_count", 32'(Count), 1);
    chk("empty_pp_code", 32'(KeyCode), 32'hA);
    cyc(1'b0, 4'hA, 1'b0, 1'b0, N);
    pop_expect("empty_pp_pop", 4'hA);

    // Asynchronous reset mid-qualification with two events queued
    press(4'hB, 1'b0);
    press(4'hC, 1'b0);
    chk("pre_rst_count", 32'(Count), 2);
    cyc(1'b1, 4'h4, 1'b0, 1'b0, 2);
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_count", 32'(Count), 0);
    chk("arst_valid", 32'(KeyValid), 0);
    chk("arst_code", 32'(KeyCode), 0);
    chk("arst_en", 32'(EnableKeyb), 0);
    chk("arst_ovf", 32'(Overflow), 0);
    repeat (2) tick();
    RESET_N = 1'b1;
    cyc(1'b1, 4'h4, 1'b0, 1'b0, 3);
    chk("rst_newpress_3", 32'(Count), 0);
    cyc(1'b1, 4'h4, 1'b0, 1'b0, 1);
    chk("rst_newpress_4", 32'(Count), 1);
    chk("rst_newpress_code", 32'(KeyCode), 32'h4);
    cyc(1'b0, 4'h4, 1'b0, 1'b0, N);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
